// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and constants for the writeback arbiter slice.
//   - Default geometry of the writeback path (sources, lanes, field widths)
//   - WB_IDX_BITS : width of a source index / round-robin pointer
//   - arb_state_t : lock state of the round-robin arbiter
//   - wb_pkt_t    : one result packet as carried on the writeback stream
//   - wb_next_idx : modulo-NUM_REQS increment (NUM_REQS need not be 2^n)
// Optional feature elsewhere in the slice: WB_ARB_PERF_EN (stall counter).
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int WB_NUM_REQS      = 5;
    localparam int WB_NUM_THREADS   = 4;
    localparam int WB_XLEN          = 32;
    localparam int WB_NW_BITS       = 2;
    localparam int WB_NR_BITS       = 6;
    localparam int WB_UUID_BITS     = 44;
    localparam int WB_PERF_CTR_BITS = 44;

    localparam int WB_IDX_BITS = (WB_NUM_REQS > 1) ? $clog2(WB_NUM_REQS) : 1;

    typedef enum logic {
        ARB_OPEN   = 1'b0,   // any source may win, round-robin from ptr
        ARB_LOCKED = 1'b1    // mid-instruction: only the lock owner may win
    } arb_state_t;

    typedef struct packed {
        logic [WB_UUID_BITS-1:0]                   uuid;
        logic [WB_NW_BITS-1:0]                     wid;
        logic [WB_NUM_THREADS-1:0]                 tmask;
        logic [WB_XLEN-1:0]                        PC;
        logic [WB_NR_BITS-1:0]                     rd;
        logic                                      wb;
        logic [WB_NUM_THREADS-1:0][WB_XLEN-1:0]    data;
        logic                                      eop;
    } wb_pkt_t;

    // Explicit wrap so a non-power-of-two source count never lands on an
    // unused index.
    function automatic int wb_next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// -----------------------------------------------------------------------------
// writeback_arbiter_if
// Bundles the execute-unit request side and the writeback output side.
//   req_valid/req_ready   : per-source handshake
//   req_uuid..req_eop     : per-source packet fields
//   wb_valid, wb_*        : registered writeback packet (no backpressure)
// Modports:
//   master : execute units + writeback consumer (drives req_*, sees ready/wb_*)
//   slave  : the arbiter
// -----------------------------------------------------------------------------
interface writeback_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQS    = WB_NUM_REQS,
    parameter int NUM_THREADS = WB_NUM_THREADS,
    parameter int XLEN        = WB_XLEN,
    parameter int NW_BITS     = WB_NW_BITS,
    parameter int NR_BITS     = WB_NR_BITS,
    parameter int UUID_BITS   = WB_UUID_BITS
);
    logic [NUM_REQS-1:0]                              req_valid;
    logic [NUM_REQS-1:0]                              req_ready;
    logic [NUM_REQS-1:0][UUID_BITS-1:0]               req_uuid;
    logic [NUM_REQS-1:0][NW_BITS-1:0]                 req_wid;
    logic [NUM_REQS-1:0][NUM_THREADS-1:0]             req_tmask;
    logic [NUM_REQS-1:0][XLEN-1:0]                    req_PC;
    logic [NUM_REQS-1:0][NR_BITS-1:0]                 req_rd;
    logic [NUM_REQS-1:0]                              req_wb;
    logic [NUM_REQS-1:0][NUM_THREADS-1:0][XLEN-1:0]   req_data;
    logic [NUM_REQS-1:0]                              req_eop;

    logic                                             wb_valid;
    logic [UUID_BITS-1:0]                             wb_uuid;
    logic [NW_BITS-1:0]                               wb_wid;
    logic [NUM_THREADS-1:0]                           wb_tmask;
    logic [XLEN-1:0]                                  wb_PC;
    logic [NR_BITS-1:0]                               wb_rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]                 wb_data;
    logic                                             wb_eop;

    modport master (
        output req_valid, req_uuid, req_wid, req_tmask, req_PC, req_rd,
               req_wb, req_data, req_eop,
        input  req_ready,
        input  wb_valid, wb_uuid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop
    );

    modport slave (
        input  req_valid, req_uuid, req_wid, req_tmask, req_PC, req_rd,
               req_wb, req_data, req_eop,
        output req_ready,
        output wb_valid, wb_uuid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop
    );

endinterface

// File: rtl/rr_lock_arbiter.sv
// -----------------------------------------------------------------------------
// rr_lock_arbiter
// Round-robin arbiter with a per-requestor lock for multi-packet results.
//   clk, reset : clock, synchronous active-high reset
//   i_valid    : request per source
//   i_eop      : eop flag of the currently granted source's packet
//   i_fire     : the granted packet is accepted this cycle
//   o_grant    : one-hot grant (zero when nothing is granted)
//   o_index    : binary index of the granted source
// Owns the round-robin pointer and the lock state/owner.
// -----------------------------------------------------------------------------
module rr_lock_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQS = WB_NUM_REQS,
    localparam int IDX_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] i_valid,
    input  logic                i_eop,
    input  logic                i_fire,
    output logic [NUM_REQS-1:0] o_grant,
    output logic [IDX_W-1:0]    o_index
);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_next;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] w_lock_idx_next;
    logic             w_any;
    int               w_cand;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ARB_OPEN;
            r_ptr      <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_lock_idx <= w_lock_idx_next;
        end
    end

    always_comb begin
        o_grant         = '0;
        o_index         = '0;
        w_any           = 1'b0;
        w_cand          = 0;
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_lock_idx_next = r_lock_idx;

        if (r_state == ARB_LOCKED) begin
            // The owner alone may proceed; if it stalls, nobody is granted.
            if (i_valid[r_lock_idx]) begin
                w_any   = 1'b1;
                o_index = r_lock_idx;
            end
        end else begin
            // Scan ptr, ptr+1, ... wrapping; first valid wins.
            for (int k = 0; k < NUM_REQS; k++) begin
                w_cand = int'(r_ptr) + k;
                if (w_cand >= NUM_REQS) begin
                    w_cand = w_cand - NUM_REQS;
                end
                if (!w_any && i_valid[w_cand]) begin
                    w_any   = 1'b1;
                    o_index = IDX_W'(w_cand);
                end
            end
        end

        if (w_any) begin
            o_grant[o_index] = 1'b1;
        end

        if (i_fire && w_any) begin
            if (i_eop) begin
                // Finished instruction: its source drops to lowest priority.
                w_state_next = ARB_OPEN;
                w_ptr_next   = IDX_W'(wb_next_idx(int'(o_index), NUM_REQS));
            end else begin
                w_state_next    = ARB_LOCKED;
                w_lock_idx_next = o_index;
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
// Merges execute-unit result packets into one registered writeback stream.
//   clk, reset  : clock, synchronous active-high reset
//   bus (slave) : req_* from execute units, req_ready back, wb_* to issue stage
//   perf_stalls : cycles in which some valid source was not granted
//                 (port present only when WB_ARB_PERF_EN is defined)
// Packets with wb=0 are accepted (and advance ptr/lock) but never reach the
// output. Output latency is one cycle; the consumer never backpressures.
// -----------------------------------------------------------------------------
module writeback_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQS      = WB_NUM_REQS,
    parameter int NUM_THREADS   = WB_NUM_THREADS,
    parameter int XLEN          = WB_XLEN,
    parameter int NW_BITS       = WB_NW_BITS,
    parameter int NR_BITS       = WB_NR_BITS,
    parameter int UUID_BITS     = WB_UUID_BITS,
    parameter int PERF_CTR_BITS = WB_PERF_CTR_BITS,
    localparam int IDX_W        = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    writeback_arbiter_if.slave       bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0] perf_stalls
`endif
);

    logic [NUM_REQS-1:0] w_grant;
    logic [IDX_W-1:0]    w_index;
    logic                w_fire;
    logic                w_load;

    logic [UUID_BITS-1:0]              w_uuid;
    logic [NW_BITS-1:0]                w_wid;
    logic [NUM_THREADS-1:0]            w_tmask;
    logic [XLEN-1:0]                   w_PC;
    logic [NR_BITS-1:0]                w_rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]  w_data;

    wb_pkt_t w_pkt;
    wb_pkt_t r_pkt;
    logic    r_wb_valid;

    rr_lock_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_valid (bus.req_valid),
        .i_eop   (bus.req_eop[w_index]),
        .i_fire  (w_fire),
        .o_grant (w_grant),
        .o_index (w_index)
    );

    // Downstream always accepts, so any grant is an accept.
    assign w_fire        = |w_grant;
    assign bus.req_ready = w_grant;

    // Payload mux on the granted index.
    assign w_uuid  = bus.req_uuid[w_index];
    assign w_wid   = bus.req_wid[w_index];
    assign w_tmask = bus.req_tmask[w_index];
    assign w_PC    = bus.req_PC[w_index];
    assign w_rd    = bus.req_rd[w_index];
    assign w_data  = bus.req_data[w_index];

    always_comb begin
        w_pkt       = '0;
        w_pkt.uuid  = w_uuid;
        w_pkt.wid   = w_wid;
        w_pkt.tmask = w_tmask;
        w_pkt.PC    = w_PC;
        w_pkt.rd    = w_rd;
        w_pkt.wb    = bus.req_wb[w_index];
        w_pkt.data  = w_data;
        w_pkt.eop   = bus.req_eop[w_index];
    end

    // Non-writeback packets are consumed here and never reach the stream.
    assign w_load = w_fire && w_pkt.wb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_pkt      <= '0;
        end else begin
            r_wb_valid <= w_load;
            if (w_load) begin
                r_pkt <= w_pkt;
            end
        end
    end

    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_uuid  = r_pkt.uuid;
    assign bus.wb_wid   = r_pkt.wid;
    assign bus.wb_tmask = r_pkt.tmask;
    assign bus.wb_PC    = r_pkt.PC;
    assign bus.wb_rd    = r_pkt.rd;
    assign bus.wb_data  = r_pkt.data;
    assign bus.wb_eop   = r_pkt.eop;

`ifdef WB_ARB_PERF_EN
    logic [PERF_CTR_BITS-1:0] r_perf_stalls;
    logic                     w_stall;

    assign w_stall = |(bus.req_valid & ~w_grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stalls <= '0;
        end else if (w_stall && (r_perf_stalls != '1)) begin
            r_perf_stalls <= r_perf_stalls + 1'b1;
        end
    end

    assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
// Directed, table-driven bench for writeback_arbiter. Each table row is one
// clock cycle: the inputs driven, the expected req_ready before the edge, and
// which source's packet (if any) must appear on wb_* after the edge.
// With WB_ARB_PERF_EN defined, a rotation/stall-counter sequence is added.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;
    import wb_arb_pkg::*;

    localparam int NR = WB_NUM_REQS;
    localparam int NT = WB_NUM_THREADS;

    typedef struct {
        logic        rst;
        logic [4:0]  valid;
        logic [4:0]  eop;
        logic [4:0]  wb;
        logic [4:0]  exp_ready;
        logic        exp_wbv;
        int          exp_src;
    } vec_t;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;
    vec_t vecs[$];

    writeback_arbiter_if bus ();

`ifdef WB_ARB_PERF_EN
    logic [WB_PERF_CTR_BITS-1:0] perf_stalls;
`endif

    writeback_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_stalls (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] f_rd(input int i, input int s);
        return 6'((i * 5 + s * 11 + 3) % 64);
    endfunction

    function automatic logic [31:0] f_data(input int i, input int s, input int t);
        return {8'(i), 8'(s), 8'(t), 8'hA5};
    endfunction

    function automatic logic [43:0] f_uuid(input int i, input int s);
        return 44'(i * 256 + s);
    endfunction

    function automatic logic [31:0] f_pc(input int i, input int s);
        return 32'h8000_0000 + 32'(i * 64 + s * 4);
    endfunction

    // Expected {wid, tmask, PC, uuid, eop} for source s at step i.
    function automatic logic [82:0] f_meta(input int i, input int s, input logic e);
        return {2'(s), 4'(i + s), f_pc(i, s), f_uuid(i, s), e};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input int i, input vec_t v);
        reset         = v.rst;
        bus.req_valid = v.valid;
        bus.req_eop   = v.eop;
        bus.req_wb    = v.wb;
        for (int s = 0; s < NR; s++) begin
            bus.req_uuid[s]  = f_uuid(i, s);
            bus.req_wid[s]   = 2'(s);
            bus.req_tmask[s] = 4'(i + s);
            bus.req_PC[s]    = f_pc(i, s);
            bus.req_rd[s]    = f_rd(i, s);
            for (int t = 0; t < NT; t++) begin
                bus.req_data[s][t] = f_data(i, s, t);
            end
        end
    endtask

    function automatic vec_t mkv(input logic rst, input logic [4:0] valid,
                                 input logic [4:0] eop, input logic [4:0] wb,
                                 input logic [4:0] exp_ready, input logic exp_wbv,
                                 input int exp_src);
        vec_t v;
        v.rst = rst; v.valid = valid; v.eop = eop; v.wb = wb;
        v.exp_ready = exp_ready; v.exp_wbv = exp_wbv; v.exp_src = exp_src;
        return v;
    endfunction

    initial begin
        logic [NT-1:0][31:0] exp_d;
        logic [82:0]         act_meta;
        vec_t                v;

        n_total = 0;
        n_pass  = 0;

        //               rst  valid     eop       wb        ready     wbv  src
        vecs.push_back(mkv(1, 5'b00000, 5'b11111, 5'b11111, 5'b00000, 0, 0));
        // Two sources, eop=1: 2 then 4.
        vecs.push_back(mkv(0, 5'b10100, 5'b11111, 5'b11111, 5'b00100, 1, 2));
        vecs.push_back(mkv(0, 5'b10100, 5'b11111, 5'b11111, 5'b10000, 1, 4));
        // Move ptr to 1, then source 1 sends 3 packets with source 0 waiting.
        vecs.push_back(mkv(0, 5'b00001, 5'b11111, 5'b11111, 5'b00001, 1, 0));
        vecs.push_back(mkv(0, 5'b00011, 5'b11101, 5'b11111, 5'b00010, 1, 1));
        vecs.push_back(mkv(0, 5'b00011, 5'b11101, 5'b11111, 5'b00010, 1, 1));
        vecs.push_back(mkv(0, 5'b00011, 5'b11111, 5'b11111, 5'b00010, 1, 1));
        vecs.push_back(mkv(0, 5'b00001, 5'b11111, 5'b11111, 5'b00001, 1, 0));
        // Source 3 locks, stalls two cycles with source 0 valid, then finishes.
        vecs.push_back(mkv(0, 5'b01001, 5'b10111, 5'b11111, 5'b01000, 1, 3));
        vecs.push_back(mkv(0, 5'b00001, 5'b10111, 5'b11111, 5'b00000, 0, 0));
        vecs.push_back(mkv(0, 5'b00001, 5'b10111, 5'b11111, 5'b00000, 0, 0));
        vecs.push_back(mkv(0, 5'b01001, 5'b10111, 5'b11111, 5'b01000, 1, 3));
        vecs.push_back(mkv(0, 5'b01001, 5'b11111, 5'b11111, 5'b01000, 1, 3));
        vecs.push_back(mkv(0, 5'b00001, 5'b11111, 5'b11111, 5'b00001, 1, 0));
        // wb=0 packet from 2: accepted, not output, ptr -> 3.
        vecs.push_back(mkv(0, 5'b00100, 5'b11111, 5'b11011, 5'b00100, 0, 0));
        vecs.push_back(mkv(0, 5'b11111, 5'b11111, 5'b11111, 5'b01000, 1, 3));
        vecs.push_back(mkv(0, 5'b00111, 5'b11111, 5'b11111, 5'b00001, 1, 0));
        // Source 1 locks, then reset while locked.
        vecs.push_back(mkv(0, 5'b00010, 5'b11101, 5'b11111, 5'b00010, 1, 1));
        vecs.push_back(mkv(1, 5'b00010, 5'b11101, 5'b11111, 5'b00010, 0, 0));
        vecs.push_back(mkv(0, 5'b11111, 5'b11111, 5'b11111, 5'b00001, 1, 0));
        vecs.push_back(mkv(0, 5'b11111, 5'b11111, 5'b11111, 5'b00010, 1, 1));
        // Source 1 just finished: it is now lowest priority.
        vecs.push_back(mkv(0, 5'b00011, 5'b11111, 5'b11111, 5'b00001, 1, 0));
        // Lone continuous requestor is granted every cycle.
        vecs.push_back(mkv(0, 5'b00010, 5'b11111, 5'b11111, 5'b00010, 1, 1));
        vecs.push_back(mkv(0, 5'b00010, 5'b11111, 5'b11111, 5'b00010, 1, 1));
        vecs.push_back(mkv(0, 5'b00000, 5'b11111, 5'b11111, 5'b00000, 0, 0));

        // Reset state.
        v = mkv(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0);
        drive(0, v);
        repeat (2) @(posedge clk);
        #1;
        check("reset_wb_valid", 128'(bus.wb_valid), 128'(0));
        check("reset_wb_rd",    128'(bus.wb_rd),    128'(0));
        check("reset_wb_data",  128'(bus.wb_data),  128'(0));
        act_meta = {bus.wb_wid, bus.wb_tmask, bus.wb_PC, bus.wb_uuid, bus.wb_eop};
        check("reset_wb_meta",  128'(act_meta),     128'(0));
`ifdef WB_ARB_PERF_EN
        check("reset_perf",     128'(perf_stalls),  128'(0));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(i, vecs[i]);
            #1;
            check($sformatf("ready[%0d]", i), 128'(bus.req_ready), 128'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("wb_valid[%0d]", i), 128'(bus.wb_valid), 128'(vecs[i].exp_wbv));
            if (vecs[i].exp_wbv) begin
                for (int t = 0; t < NT; t++) begin
                    exp_d[t] = f_data(i, vecs[i].exp_src, t);
                end
                act_meta = {bus.wb_wid, bus.wb_tmask, bus.wb_PC, bus.wb_uuid, bus.wb_eop};
                check($sformatf("wb_rd[%0d]", i), 128'(bus.wb_rd),
                      128'(f_rd(i, vecs[i].exp_src)));
                check($sformatf("wb_data[%0d]", i), 128'(bus.wb_data), 128'(exp_d));
                check($sformatf("wb_meta[%0d]", i), 128'(act_meta),
                      128'(f_meta(i, vecs[i].exp_src, vecs[i].eop[vecs[i].exp_src])));
            end
            $display("step %0d rst=%b valid=%b ready=%b wb_valid=%b wb_rd=%0d",
                     i, vecs[i].rst, vecs[i].valid, bus.req_ready, bus.wb_valid, bus.wb_rd);
        end

`ifdef WB_ARB_PERF_EN
        // All five valid for 10 cycles: rotation 0..4,0.. and 10 stall cycles.
        @(negedge clk);
        v = mkv(1, 5'b00000, 5'b11111, 5'b11111, 5'b00000, 0, 0);
        drive(0, v);
        @(posedge clk);
        #1;
        check("perf_after_reset", 128'(perf_stalls), 128'(0));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            v = mkv(0, 5'b11111, 5'b11111, 5'b11111, 5'b00000, 0, 0);
            drive(c, v);
            #1;
            check($sformatf("rotate[%0d]", c), 128'(bus.req_ready), 128'(5'b00001 << (c % 5)));
            $display("rotate %0d ready=%b", c, bus.req_ready);
            @(posedge clk);
        end
        @(negedge clk);
        v = mkv(0, 5'b00000, 5'b11111, 5'b11111, 5'b00000, 0, 0);
        drive(0, v);
        #1;
        check("perf_stalls", 128'(perf_stalls), 128'(10));
        $display("perf_stalls=%0d", perf_stalls);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
